adc_sample_framer: RTL and testbench

// - Downstream consumer of the ADC reader's 24-bit ch1 word and its ready strobe.
// - Crosses ready into clk domain; boxcar-averages 2^AVG_LOG2 signed samples; buffers results in a FIFO.
// - Emits each result as a byte frame on a valid/ready stream for the UART/USB transmitter.

---
 rtl/adc_sample_framer.sv | 247 ++++++++++++++++++++++++
 tb/tb_adc_sample_framer.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_sample_framer.sv
// ADC sample framer: synchronizes the ADC ready strobe, boxcar-averages samples,
// queues results and streams each one as an A5-headed byte frame. Optional macro: ADC_FRAME_CHECKSUM_EN.
module adc_sample_framer #(
  parameter int AVG_LOG2   = 2,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst_l,
  input  logic        sample_ready,
  input  logic [23:0] sample_data,
  input  logic        enable,
  input  logic        clear_stat,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        overflow,
  output logic [7:0]  drop_cnt
);

  localparam int AW = 24 + AVG_LOG2;
  localparam int CW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] CNT_LAST = CW'((1 << AVG_LOG2) - 1);

  typedef enum logic [2:0] {
    TX_IDLE = 3'd0,
    TX_HDR  = 3'd1,
    TX_B2   = 3'd2,
    TX_B1   = 3'd3,
`ifdef ADC_FRAME_CHECKSUM_EN
    TX_B0   = 3'd4,
    TX_CHK  = 3'd5
`else
    TX_B0   = 3'd4
`endif
  } tx_state_t;

`ifdef ADC_FRAME_CHECKSUM_EN
  function automatic logic [7:0] frame_checksum(input logic [23:0] w);
    return w[23:16] ^ w[15:8] ^ w[7:0];
  endfunction
`endif

  logic                 s1_r, s2_r, s3_r;
  logic                 stb_s;
  logic signed [23:0]   sample_s;
  logic signed [AW-1:0] sample_ext_s;
  logic signed [AW-1:0] acc_r;
  logic signed [AW-1:0] sum_s;
  logic        [23:0]   avg_s;
  logic [CW-1:0]        cnt_r;
  logic [23:0]          result_r;
  logic                 result_vld_r;

  logic [23:0]          mem_r [FIFO_DEPTH];
  logic [PW:0]          wr_ptr_r, rd_ptr_r;
  logic                 empty_s, full_s;
  logic                 push_s, drop_s, pop_s;

  tx_state_t            state_r, state_nxt;
  logic [23:0]          word_r, word_nxt;
  logic [7:0]           tx_data_nxt;
  logic                 tx_valid_nxt;
  logic                 accept_s;

  assign stb_s        = s2_r & ~s3_r;
  assign sample_s     = sample_data;
  assign sample_ext_s = AW'(sample_s);
  assign sum_s        = acc_r + sample_ext_s;
  assign avg_s        = 24'(sum_s >>> AVG_LOG2);

  // Two-flop synchronizer plus edge-detect flop for the asynchronous ready strobe
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      s1_r <= 1'b0;
      s2_r <= 1'b0;
      s3_r <= 1'b0;
    end else begin
      s1_r <= sample_ready;
      s2_r <= s1_r;
      s3_r <= s2_r;
    end
  end

  // Boxcar accumulator; the final sample is folded in directly so acc restarts at zero
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      acc_r        <= '0;
      cnt_r        <= '0;
      result_r     <= 24'h000000;
      result_vld_r <= 1'b0;
    end else begin
      result_vld_r <= 1'b0;
      if (!enable) begin
        acc_r <= '0;
        cnt_r <= '0;
      end else if (stb_s) begin
        if (cnt_r == CNT_LAST) begin
          acc_r        <= '0;
          cnt_r        <= '0;
          result_r     <= avg_s;
          result_vld_r <= 1'b1;
        end else begin
          acc_r <= sum_s;
          cnt_r <= cnt_r + CW'(1);
        end
      end
    end
  end

  assign empty_s = (wr_ptr_r == rd_ptr_r);
  assign full_s  = (wr_ptr_r[PW] != rd_ptr_r[PW]) &&
                   (wr_ptr_r[PW-1:0] == rd_ptr_r[PW-1:0]);
  // A pop in the same cycle frees the slot, so a push into a full FIFO is still accepted
  assign push_s  = result_vld_r & (~full_s | pop_s);
  assign drop_s  = result_vld_r & full_s & ~pop_s;

  // Result storage array
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r[PW-1:0]] <= result_r;
    end
  end

  // FIFO pointers
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + (PW+1)'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + (PW+1)'(1);
      end
    end
  end

  // Drop statistics; a clear wins over a drop in the same cycle
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      overflow <= 1'b0;
      drop_cnt <= 8'h00;
    end else if (clear_stat) begin
      overflow <= 1'b0;
      drop_cnt <= 8'h00;
    end else if (drop_s) begin
      overflow <= 1'b1;
      if (drop_cnt != 8'hFF) begin
        drop_cnt <= drop_cnt + 8'd1;
      end
    end
  end

  assign accept_s = tx_valid & tx_ready;

  // Frame sequencer: next state, next byte and FIFO pop
  always_comb begin
    state_nxt    = state_r;
    word_nxt     = word_r;
    tx_data_nxt  = tx_data;
    tx_valid_nxt = tx_valid;
    pop_s        = 1'b0;
    case (state_r)
      TX_IDLE: begin
        // A frame starts only toward a ready sink, so backpressured results stay queued
        if (!empty_s && tx_ready) begin
          pop_s        = 1'b1;
          word_nxt     = mem_r[rd_ptr_r[PW-1:0]];
          tx_data_nxt  = 8'hA5;
          tx_valid_nxt = 1'b1;
          state_nxt    = TX_HDR;
        end else begin
          tx_valid_nxt = 1'b0;
        end
      end
      TX_HDR: begin
        if (accept_s) begin
          tx_data_nxt = word_r[23:16];
          state_nxt   = TX_B2;
        end else begin
          state_nxt = TX_HDR;
        end
      end
      TX_B2: begin
        if (accept_s) begin
          tx_data_nxt = word_r[15:8];
          state_nxt   = TX_B1;
        end else begin
          state_nxt = TX_B2;
        end
      end
      TX_B1: begin
        if (accept_s) begin
          tx_data_nxt = word_r[7:0];
          state_nxt   = TX_B0;
        end else begin
          state_nxt = TX_B1;
        end
      end
      TX_B0: begin
        if (accept_s) begin
`ifdef ADC_FRAME_CHECKSUM_EN
          tx_data_nxt = frame_checksum(word_r);
          state_nxt   = TX_CHK;
`else
          tx_valid_nxt = 1'b0;
          state_nxt    = TX_IDLE;
`endif
        end else begin
          state_nxt = TX_B0;
        end
      end
`ifdef ADC_FRAME_CHECKSUM_EN
      TX_CHK: begin
        if (accept_s) begin
          tx_valid_nxt = 1'b0;
          state_nxt    = TX_IDLE;
        end else begin
          state_nxt = TX_CHK;
        end
      end
`endif
      default: begin
        tx_valid_nxt = 1'b0;
        state_nxt    = TX_IDLE;
      end
    endcase
  end

  // Sequencer state and registered stream outputs
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_r  <= TX_IDLE;
      word_r   <= 24'h000000;
      tx_data  <= 8'h00;
      tx_valid <= 1'b0;
    end else begin
      state_r  <= state_nxt;
      word_r   <= word_nxt;
      tx_data  <= tx_data_nxt;
      tx_valid <= tx_valid_nxt;
    end
  end

endmodule

// File: tb/tb_adc_sample_framer.sv
// Bench for adc_sample_framer: directed scenarios plus randomized samples checked
// against an arithmetic averaging model and a byte-stream scoreboard.
module tb_adc_sample_framer;

  localparam int AVG_LOG2   = 2;
  localparam int FIFO_DEPTH = 8;
  localparam int NAVG       = 1 << AVG_LOG2;

  logic        clk = 1'b0;
  logic        rst_l = 1'b0;
  logic        sample_ready = 1'b0;
  logic [23:0] sample_data = 24'h000000;
  logic        enable = 1'b0;
  logic        clear_stat = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic        overflow;
  logic [7:0]  drop_cnt;

  int tests = 0;
  int fails = 0;
  bit rand_ready = 1'b0;
  int lat;

  logic [7:0]  got_q[$];
  logic [7:0]  exp_q[$];
  logic [23:0] m_res_q[$];
  longint      m_acc = 0;
  int          m_cnt = 0;

  logic        hold_prev = 1'b0;
  logic [7:0]  data_prev = 8'h00;

  always #5 clk = ~clk;

  adc_sample_framer #(.AVG_LOG2(AVG_LOG2), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .rst_l(rst_l), .sample_ready(sample_ready), .sample_data(sample_data),
    .enable(enable), .clear_stat(clear_stat), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .overflow(overflow), .drop_cnt(drop_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) tx_ready = 1'($urandom_range(0, 1));
  endtask

  // Reference: average of NAVG signed samples, floor division, low 24 bits
  task automatic model_sample(input logic [23:0] d);
    longint q;
    if (!enable) begin
      m_acc = 0;
      m_cnt = 0;
    end else begin
      m_acc += longint'(signed'(d));
      m_cnt++;
      if (m_cnt == NAVG) begin
        q = m_acc >>> AVG_LOG2;
        m_res_q.push_back(q[23:0]);
        m_acc = 0;
        m_cnt = 0;
      end
    end
  endtask

  task automatic push_frame(input logic [23:0] w);
    exp_q.push_back(8'hA5);
    exp_q.push_back(w[23:16]);
    exp_q.push_back(w[15:8]);
    exp_q.push_back(w[7:0]);
`ifdef ADC_FRAME_CHECKSUM_EN
    exp_q.push_back(w[23:16] ^ w[15:8] ^ w[7:0]);
`endif
  endtask

  task automatic flush_model(input int limit);
    for (int i = 0; i < m_res_q.size() && i < limit; i++) push_frame(m_res_q[i]);
    m_res_q.delete();
  endtask

  task automatic send_sample(input logic [23:0] d);
    sample_data = d;
    sample_ready = 1'b1;
    model_sample(d);
    lat = -1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (i == 4) sample_ready = 1'b0;
      if (lat < 0 && tx_valid) lat = i;
    end
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while ((got_q.size() < exp_q.size() || tx_valid) && n < 3000) begin
      tick();
      n++;
    end
    check({tag, "_len"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check({tag, "_byte"}, got_q[i], exp_q[i]);
    got_q.delete();
    exp_q.delete();
  endtask

  // Byte collector and hold-stability check, sampled on the falling edge
  always @(negedge clk) begin
    if (!rst_l) begin
      hold_prev = 1'b0;
    end else begin
      if (hold_prev) begin
        check("hold_valid", tx_valid, 1);
        check("hold_data", tx_data, data_prev);
      end
      if (tx_valid && tx_ready) got_q.push_back(tx_data);
      hold_prev = tx_valid && !tx_ready;
      data_prev = tx_data;
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    // Reset values
    repeat (3) tick();
    check("rst_tx_data", tx_data, 8'h00);
    check("rst_tx_valid", tx_valid, 1'b0);
    check("rst_overflow", overflow, 1'b0);
    check("rst_drop_cnt", drop_cnt, 8'h00);
    rst_l = 1'b1;
    enable = 1'b1;
    tx_ready = 1'b1;
    repeat (2) tick();

    // Directed average and latency
    send_sample(24'h000010);
    send_sample(24'h000020);
    send_sample(24'h000030);
    send_sample(24'h000040);
    check("latency_le6", (lat > 0 && lat <= 6), 1);
    m_res_q.delete();
    push_frame(24'h000028);
    wait_drain("avg_pos");

    // Negative samples
    repeat (4) send_sample(24'hFFFFF0);
    m_res_q.delete();
    push_frame(24'hFFFFF0);
    wait_drain("avg_neg");

    // Backpressure on the header byte
    repeat (3) send_sample(24'($urandom));
    sample_data = 24'($urandom);
    sample_ready = 1'b1;
    model_sample(sample_data);
    n = 0;
    while (!tx_valid && n < 20) begin
      tick();
      n++;
    end
    tx_ready = 1'b0;
    repeat (10) tick();
    check("bp_valid", tx_valid, 1'b1);
    check("bp_data", tx_data, 8'hA5);
    sample_ready = 1'b0;
    tx_ready = 1'b1;
    flush_model(100);
    wait_drain("bp");

    // Random samples with random sink readiness
    rand_ready = 1'b1;
    for (int k = 0; k < 20 * NAVG; k++) send_sample(24'($urandom));
    rand_ready = 1'b0;
    tx_ready = 1'b1;
    flush_model(100);
    wait_drain("rand");
    check("rand_overflow", overflow, 1'b0);
    check("rand_drop_cnt", drop_cnt, 8'h00);

    // FIFO overflow with the sink stalled
    tx_ready = 1'b0;
    for (int k = 0; k < (FIFO_DEPTH + 1) * NAVG; k++) send_sample(24'($urandom));
    check("ovf_flag", overflow, 1'b1);
    check("ovf_drop_cnt", drop_cnt, 8'h01);
    tick();
    clear_stat = 1'b1;
    tick();
    clear_stat = 1'b0;
    tick();
    check("clr_flag", overflow, 1'b0);
    check("clr_drop_cnt", drop_cnt, 8'h00);
    tx_ready = 1'b1;
    flush_model(FIFO_DEPTH);
    wait_drain("ovf");

    // enable=0 discards samples and the partial accumulation
    send_sample(24'h123456);
    send_sample(24'h654321);
    enable = 1'b0;
    model_sample(24'h000000);
    repeat (3) send_sample(24'($urandom));
    repeat (10) tick();
    check("dis_noframe", got_q.size(), 0);
    enable = 1'b1;
    for (int k = 0; k < NAVG; k++) send_sample(24'($urandom));
    flush_model(100);
    wait_drain("dis");

    // Reset in the middle of a frame
    repeat (3) send_sample(24'($urandom));
    sample_data = 24'($urandom);
    sample_ready = 1'b1;
    model_sample(sample_data);
    n = 0;
    while (!tx_valid && n < 20) begin
      tick();
      n++;
    end
    tx_ready = 1'b0;
    tick();
    tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0;
    check("mid_b2_data", tx_data, m_res_q[0][23:16]);
    rst_l = 1'b0;
    sample_ready = 1'b0;
    #1;
    check("mid_rst_valid", tx_valid, 1'b0);
    check("mid_rst_data", tx_data, 8'h00);
    got_q.delete();
    exp_q.delete();
    m_res_q.delete();
    m_acc = 0;
    m_cnt = 0;
    repeat (2) tick();
    rst_l = 1'b1;
    tx_ready = 1'b1;
    repeat (10) tick();
    check("post_rst_noframe", got_q.size(), 0);
    for (int k = 0; k < NAVG; k++) send_sample(24'($urandom));
    flush_model(100);
    wait_drain("post_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
